// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared MIPS pipeline constants: stall FSM encoding, register/opcode constants
// and the load-use hazard test used by the stall controller.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    // $0 is never a real producer, so a load targeting it cannot create a hazard.
    function automatic logic loadUseHazard(input logic       memRead,
                                           input logic [4:0] exRt,
                                           input logic [4:0] idRs,
                                           input logic [4:0] idRt,
                                           input logic       rtUsed);
        return memRead && (exRt != REG_ZERO) &&
               ((exRt == idRs) || (rtUsed && (exRt == idRt)));
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle between the stall controller (slave) and the pipeline datapath (master):
// decoded hazard inputs, data-memory handshake, control outputs and counters.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic             if_id_rt_used;
    logic             if_id_jump;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rt;
    logic             ex_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             perf_clr;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport slave (
        input  if_id_rs, if_id_rt, if_id_rt_used, if_id_jump, id_ex_mem_read,
               id_ex_rt, ex_branch_taken, dmem_req, dmem_ready, perf_clr,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               mem_timeout, stall_cycles, flush_events
    );

    modport master (
        output if_id_rs, if_id_rt, if_id_rt_used, if_id_jump, id_ex_mem_read,
               id_ex_rt, ex_branch_taken, dmem_req, dmem_ready, perf_clr,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               mem_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS core: load-use and control hazard
// handling, data-memory freeze with timeout, and stall/flush performance counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_stall_ctrl_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic              memTimeout_q, memTimeout_d;

    logic memBusy;
    logic loadUse;
    logic pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeHold;

    assign memBusy = bus.dmem_req && !bus.dmem_ready;
    assign loadUse = loadUseHazard(bus.id_ex_mem_read, bus.id_ex_rt,
                                   bus.if_id_rs, bus.if_id_rt, bus.if_id_rt_used);

    always_comb begin
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        memTimeout_d = memTimeout_q;
        pcWrite      = 1'b1;
        ifIdWrite    = 1'b1;
        ifIdFlush    = 1'b0;
        idExFlush    = 1'b0;
        pipeHold     = 1'b0;

        // A freeze from memory overrides every hazard; otherwise branch squash beats load-use.
        if ((state_q == RUN && memBusy) || (state_q == MEM_WAIT && !bus.dmem_ready) ||
            state_q == ERROR) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            pipeHold  = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else if (loadUse) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
        end else if (bus.if_id_jump) begin
            ifIdFlush = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (memBusy) begin
                    state_d   = MEM_WAIT;
                    waitCnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_d   = RUN;
                    waitCnt_d = '0;
                end else if (waitCnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d      = ERROR;
                    memTimeout_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d   = RUN;
                waitCnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            waitCnt_q    <= '0;
            memTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            memTimeout_q <= memTimeout_d;
        end
    end

    logic [CNT_W-1:0] stallCount, flushCount;

    sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (!pcWrite),
        .clr_i  (bus.perf_clr),
        .count_o(stallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (ifIdFlush),
        .clr_i  (bus.perf_clr),
        .count_o(flushCount)
    );

    assign bus.pc_write     = pcWrite;
    assign bus.if_id_write  = ifIdWrite;
    assign bus.if_id_flush  = ifIdFlush;
    assign bus.id_ex_flush  = idExFlush;
    assign bus.pipe_hold    = pipeHold;
    assign bus.mem_timeout  = memTimeout_q;
    assign bus.stall_cycles = stallCount;
    assign bus.flush_events = flushCount;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with small timeout and 4-bit counters
// so that the timeout and saturation corners are reached quickly.
module tb_pipeline_stall_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout}
    function automatic logic [31:0] ctrlVec();
        return {26'd0, bus.pc_write, bus.if_id_write, bus.if_id_flush,
                bus.id_ex_flush, bus.pipe_hold, bus.mem_timeout};
    endfunction

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic rtUsed, input logic jump,
                                 input logic memRead, input logic [4:0] exRt,
                                 input logic branch, input logic req,
                                 input logic ready, input logic clr);
        @(negedge clk);
        bus.if_id_rs        = rs;
        bus.if_id_rt        = rt;
        bus.if_id_rt_used   = rtUsed;
        bus.if_id_jump      = jump;
        bus.id_ex_mem_read  = memRead;
        bus.id_ex_rt        = exRt;
        bus.ex_branch_taken = branch;
        bus.dmem_req        = req;
        bus.dmem_ready      = ready;
        bus.perf_clr        = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic memStall(input logic ready, input logic clr);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, ready, clr);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.if_id_rs = '0; bus.if_id_rt = '0; bus.if_id_rt_used = 1'b0;
        bus.if_id_jump = 1'b0; bus.id_ex_mem_read = 1'b0; bus.id_ex_rt = '0;
        bus.ex_branch_taken = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
        bus.perf_clr = 1'b0;

        #2;
        checkOutput("reset_ctrl",  ctrlVec(), 32'b110000);
        checkOutput("reset_stall", 32'(bus.stall_cycles), 32'd0);
        checkOutput("reset_flush", 32'(bus.flush_events), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: lw $8 in EX, add using rs=$8 in ID
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs_ctrl", ctrlVec(), 32'b000100);
        idle();
        checkOutput("lu_bubble_ctrl", ctrlVec(), 32'b110000);
        checkOutput("lu_stall_cnt", 32'(bus.stall_cycles), 32'd1);

        // No hazard on $0 or on an rt that is not read
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_zero_ctrl", ctrlVec(), 32'b110000);
        applyStimulus(5'd1, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rt_unused_ctrl", ctrlVec(), 32'b110000);
        applyStimulus(5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rt_used_ctrl", ctrlVec(), 32'b000100);
        idle();
        checkOutput("lu_rt_stall_cnt", 32'(bus.stall_cycles), 32'd2);

        // Taken branch squashes a load-use candidate
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("br_lu_ctrl", ctrlVec(), 32'b111100);
        idle();
        checkOutput("br_stall_cnt", 32'(bus.stall_cycles), 32'd2);
        checkOutput("br_flush_cnt", 32'(bus.flush_events), 32'd1);

        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("jump_ctrl", ctrlVec(), 32'b111000);
        idle();
        checkOutput("jump_flush_cnt", 32'(bus.flush_events), 32'd2);

        // Memory ready after 3 busy cycles; jump during wait is ignored
        memStall(1'b0, 1'b0);
        checkOutput("mw_c1_ctrl", ctrlVec(), 32'b000010);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mw_c2_jump_ignored", ctrlVec(), 32'b000010);
        memStall(1'b0, 1'b0);
        checkOutput("mw_c3_ctrl", ctrlVec(), 32'b000010);
        memStall(1'b1, 1'b0);
        checkOutput("mw_ready_ctrl", ctrlVec(), 32'b110000);
        idle();
        checkOutput("mw_back_run_ctrl", ctrlVec(), 32'b110000);
        checkOutput("mw_stall_cnt", 32'(bus.stall_cycles), 32'd5);
        checkOutput("mw_flush_cnt", 32'(bus.flush_events), 32'd2);

        // Ready arriving with a taken branch uses the RUN priorities
        memStall(1'b0, 1'b0);
        checkOutput("mwbr_c1_ctrl", ctrlVec(), 32'b000010);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("mwbr_ready_ctrl", ctrlVec(), 32'b111100);
        idle();
        checkOutput("mwbr_stall_cnt", 32'(bus.stall_cycles), 32'd6);
        checkOutput("mwbr_flush_cnt", 32'(bus.flush_events), 32'd3);

        // Timeout: four unacknowledged cycles then frozen in ERROR
        for (int i = 0; i < 4; i++) begin
            memStall(1'b0, 1'b0);
            checkOutput($sformatf("to_c%0d_ctrl", i + 1), ctrlVec(), 32'b000010);
        end
        memStall(1'b1, 1'b0);
        checkOutput("err_ready_ignored", ctrlVec(), 32'b000011);
        checkOutput("err_stall_cnt", 32'(bus.stall_cycles), 32'd10);
        idle();
        checkOutput("err_idle_ctrl", ctrlVec(), 32'b000011);
        checkOutput("err_stall_cnt2", 32'(bus.stall_cycles), 32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("err_reset_ctrl", ctrlVec(), 32'b110000);
        checkOutput("err_reset_stall", 32'(bus.stall_cycles), 32'd0);
        checkOutput("err_reset_flush", 32'(bus.flush_events), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the stall counter, then clear during a stall
        for (int i = 0; i < 16; i++) begin
            memStall(1'b0, 1'b0);
        end
        memStall(1'b0, 1'b0);
        checkOutput("sat_stall_cnt", 32'(bus.stall_cycles), 32'd15);
        checkOutput("sat_ctrl", ctrlVec(), 32'b000011);
        memStall(1'b0, 1'b0);
        checkOutput("sat_hold_cnt", 32'(bus.stall_cycles), 32'd15);
        memStall(1'b0, 1'b1);
        checkOutput("clr_cycle_cnt", 32'(bus.stall_cycles), 32'd15);
        memStall(1'b0, 1'b0);
        checkOutput("clr_result_cnt", 32'(bus.stall_cycles), 32'd0);
        memStall(1'b0, 1'b0);
        checkOutput("post_clr_cnt", 32'(bus.stall_cycles), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
